// File: rtl/logic_sweep_pkg.sv
// Shared types and helpers for the logic sweep checker: FSM states, the
// reference AND/OR functions and the vector count for the default width.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DONE
    } state_t;

    // Widest operand the reference functions handle; callers zero-extend.
    localparam int MAX_W         = 32;
    localparam int DEFAULT_WIDTH = 2;
    localparam int VEC_COUNT     = 2 ** (2 * DEFAULT_WIDTH);

    function automatic logic [MAX_W-1:0] expected_and(input logic [MAX_W-1:0] a,
                                                      input logic [MAX_W-1:0] b);
        return a & b;
    endfunction

    function automatic logic [MAX_W-1:0] expected_or(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b);
        return a | b;
    endfunction

endpackage

// File: rtl/logic_sweep_checker_sweep_vec_gen.sv
// Operand generator: holds each {x,y} vector HOLD cycles, then advances the
// combined 2*WIDTH-bit counter (x outer, y inner).
module sweep_vec_gen #(
    parameter int WIDTH = 2,
    parameter int HOLD  = 20,
    parameter int LOOP  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             cmp,
    output logic             last
);

    localparam int  HC_W        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam bit  STOP_AT_END = (LOOP == 0);

    logic [HC_W-1:0]      hold_cnt;
    logic [2*WIDTH-1:0]   vec;

    assign x    = vec[2*WIDTH-1:WIDTH];
    assign y    = vec[WIDTH-1:0];
    assign cmp  = (hold_cnt == HC_W'(HOLD - 1));
    assign last = &vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            vec      <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
            vec      <= '0;
        end else if (run) begin
            if (cmp) begin
                // The final vector stays on the outputs when the sweep stops.
                if (!(last && STOP_AT_END)) begin
                    vec      <= vec + 1'b1;
                    hold_cnt <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_sweep_checker.sv
// Exhaustive two-operand sweep for bitwise AND/OR DUTs: drives every vector,
// counts response mismatches and records the first failing vector.
module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int HOLD  = 20,
    parameter int LOOP  = 0,
    parameter int CNT_W = 2 * WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    input  logic [WIDTH-1:0] and_in,
    input  logic [WIDTH-1:0] or_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_x,
    output logic [WIDTH-1:0] fail_y
);

    localparam bit STOP_AT_END = (LOOP == 0);

    state_t           state;
    logic             gen_clear;
    logic             gen_run;
    logic             cmp;
    logic             last;
    logic             mismatch;
    logic [CNT_W-1:0] err_inc;
    logic [CNT_W-1:0] err_after;

    sweep_vec_gen #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD),
        .LOOP  (LOOP)
    ) u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (gen_clear),
        .run   (gen_run),
        .x     (x_out),
        .y     (y_out),
        .cmp   (cmp),
        .last  (last)
    );

    always_comb begin
        // Abort zeroes the operands; a start outside DRIVE restarts from 00/00.
        gen_clear = abort || (start && (state != ST_DRIVE));
        gen_run   = (state == ST_DRIVE) && !abort;
        mismatch  = (MAX_W'(and_in) != expected_and(MAX_W'(x_out), MAX_W'(y_out)))
                 || (MAX_W'(or_in)  != expected_or (MAX_W'(x_out), MAX_W'(y_out)));
        err_inc   = (&err_count) ? err_count : err_count + 1'b1;
        err_after = mismatch ? err_inc : err_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_x     <= '0;
            fail_y     <= '0;
        end else if (abort) begin
            // Error results stay visible after an abort until the next start.
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_x     <= '0;
                        fail_y     <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (cmp) begin
                        err_count <= err_after;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_x     <= x_out;
                            fail_y     <= y_out;
                        end
                        if (last && STOP_AT_END) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_after == '0);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: three configurations against a time-based
// reference model, plus directed scenarios with hand-derived results.
module tb_logic_sweep_checker;

    localparam int NI = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] start = '0;
    logic [NI-1:0] abort = '0;
    logic [31:0]   smask [NI];
    logic [31:0]   omask [NI];

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    // Instance 0: WIDTH=2 HOLD=4; instance 1: WIDTH=3 HOLD=1; instance 2: WIDTH=1 HOLD=2 LOOP=1
    logic [1:0] a_x, a_y, a_and, a_or, a_fx, a_fy;
    logic [4:0] a_err;
    logic       a_busy, a_done, a_pass, a_fv;
    logic [2:0] b_x, b_y, b_and, b_or, b_fx, b_fy;
    logic [6:0] b_err;
    logic       b_busy, b_done, b_pass, b_fv;
    logic [0:0] c_x, c_y, c_and, c_or, c_fx, c_fy;
    logic [2:0] c_err;
    logic       c_busy, c_done, c_pass, c_fv;

    // DUT under test is a faulty AND/OR: smask forces AND bits to 0, omask forces OR bits to 1.
    assign a_and = (a_x & a_y) & ~smask[0][1:0];
    assign a_or  = (a_x | a_y) |  omask[0][1:0];
    assign b_and = (b_x & b_y) & ~smask[1][2:0];
    assign b_or  = (b_x | b_y) |  omask[1][2:0];
    assign c_and = (c_x & c_y) & ~smask[2][0:0];
    assign c_or  = (c_x | c_y) |  omask[2][0:0];

    logic_sweep_checker #(.WIDTH(2), .HOLD(4), .LOOP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .x_out(a_x), .y_out(a_y), .and_in(a_and), .or_in(a_or),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .fail_valid(a_fv), .fail_x(a_fx), .fail_y(a_fy));

    logic_sweep_checker #(.WIDTH(3), .HOLD(1), .LOOP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .x_out(b_x), .y_out(b_y), .and_in(b_and), .or_in(b_or),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .fail_valid(b_fv), .fail_x(b_fx), .fail_y(b_fy));

    logic_sweep_checker #(.WIDTH(1), .HOLD(2), .LOOP(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .x_out(c_x), .y_out(c_y), .and_in(c_and), .or_in(c_or),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .fail_valid(c_fv), .fail_x(c_fx), .fail_y(c_fy));

    logic [31:0] o_x [NI], o_y [NI], o_err [NI], o_fx [NI], o_fy [NI];
    logic        o_busy [NI], o_done [NI], o_pass [NI], o_fv [NI];

    assign o_x[0] = 32'(a_x);   assign o_y[0] = 32'(a_y);   assign o_err[0] = 32'(a_err);
    assign o_fx[0] = 32'(a_fx); assign o_fy[0] = 32'(a_fy);
    assign o_busy[0] = a_busy;  assign o_done[0] = a_done;  assign o_pass[0] = a_pass;  assign o_fv[0] = a_fv;
    assign o_x[1] = 32'(b_x);   assign o_y[1] = 32'(b_y);   assign o_err[1] = 32'(b_err);
    assign o_fx[1] = 32'(b_fx); assign o_fy[1] = 32'(b_fy);
    assign o_busy[1] = b_busy;  assign o_done[1] = b_done;  assign o_pass[1] = b_pass;  assign o_fv[1] = b_fv;
    assign o_x[2] = 32'(c_x);   assign o_y[2] = 32'(c_y);   assign o_err[2] = 32'(c_err);
    assign o_fx[2] = 32'(c_fx); assign o_fy[2] = 32'(c_fy);
    assign o_busy[2] = c_busy;  assign o_done[2] = c_done;  assign o_pass[2] = c_pass;  assign o_fv[2] = c_fv;

    function automatic int cfg_w(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_h(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_l(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // Vector index idx encodes x in the upper half, y in the lower half.
    function automatic bit mism(input int k, input int idx);
        int w, m, x, y;
        w = cfg_w(k);
        m = (1 << w) - 1;
        x = (idx >> w) & m;
        y = idx & m;
        return ((x & y & int'(smask[k]) & m) != 0) || ((~(x | y) & int'(omask[k]) & m) != 0);
    endfunction

    // Reference model: m_t counts cycles spent driving since start.
    bit m_run [NI];
    bit m_done [NI];
    bit m_fv [NI];
    int m_t [NI];
    int m_err [NI];
    int m_fx [NI];
    int m_fy [NI];
    int mw, mh, mvec, midx, mnt, mne;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_run[k] <= 1'b0; m_done[k] <= 1'b0; m_fv[k] <= 1'b0;
                m_t[k] <= 0; m_err[k] <= 0; m_fx[k] <= 0; m_fy[k] <= 0;
            end else if (abort[k]) begin
                m_run[k] <= 1'b0; m_done[k] <= 1'b0; m_t[k] <= 0;
            end else if (!m_run[k]) begin
                if (start[k]) begin
                    m_run[k] <= 1'b1; m_done[k] <= 1'b0; m_fv[k] <= 1'b0;
                    m_t[k] <= 0; m_err[k] <= 0; m_fx[k] <= 0; m_fy[k] <= 0;
                end
            end else begin
                mw   = cfg_w(k);
                mh   = cfg_h(k);
                mvec = 1 << (2 * mw);
                midx = m_t[k] / mh;
                mnt  = m_t[k] + 1;
                mne  = m_err[k];
                if ((m_t[k] % mh) == mh - 1 && mism(k, midx)) begin
                    if (mne < (1 << (2 * mw + 1)) - 1) mne = mne + 1;
                    if (!m_fv[k]) begin
                        m_fv[k] <= 1'b1;
                        m_fx[k] <= midx >> mw;
                        m_fy[k] <= midx & ((1 << mw) - 1);
                    end
                end
                m_err[k] <= mne;
                if (mnt == mvec * mh) begin
                    if (cfg_l(k) != 0) begin
                        mnt = 0;
                    end else begin
                        m_run[k]  <= 1'b0;
                        m_done[k] <= 1'b1;
                    end
                end
                m_t[k] <= mnt;
            end
        end
    end

    function automatic int exp_idx(input int k);
        if (m_run[k])  return m_t[k] / cfg_h(k);
        if (m_done[k]) return (1 << (2 * cfg_w(k))) - 1;
        return 0;
    endfunction

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, k, act, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("x_out",      k, o_x[k],    exp_idx(k) >> cfg_w(k));
            chk("y_out",      k, o_y[k],    exp_idx(k) & ((1 << cfg_w(k)) - 1));
            chk("busy",       k, o_busy[k], m_run[k]);
            chk("done",       k, o_done[k], m_done[k]);
            chk("pass",       k, o_pass[k], m_done[k] && m_err[k] == 0);
            chk("err_count",  k, o_err[k],  m_err[k]);
            chk("fail_valid", k, o_fv[k],   m_fv[k]);
            chk("fail_x",     k, o_fx[k],   m_fx[k]);
            chk("fail_y",     k, o_fy[k],   m_fy[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (!o_done[k] && n < budget) begin
            @(negedge clk);
            if (o_busy[k]) busy_cycles++;
            n++;
        end
        chk("done_reached", k, o_done[k], 1);
    endtask

    task automatic check_zero(input int k);
        chk("rst_x", k, o_x[k], 0);       chk("rst_y", k, o_y[k], 0);
        chk("rst_busy", k, o_busy[k], 0); chk("rst_done", k, o_done[k], 0);
        chk("rst_pass", k, o_pass[k], 0); chk("rst_err", k, o_err[k], 0);
        chk("rst_fv", k, o_fv[k], 0);     chk("rst_fx", k, o_fx[k], 0);
        chk("rst_fy", k, o_fy[k], 0);
    endtask

    int bc;
    int dseen;

    initial begin
        for (int k = 0; k < NI; k++) begin
            smask[k] = '0;
            omask[k] = '0;
        end
        repeat (3) step();
        for (int k = 0; k < NI; k++) check_zero(k);
        rst_n = 1'b1;
        step();

        // Clean sweep, WIDTH=2 HOLD=4: 16 vectors x 4 cycles
        pulse_start(0);
        wait_done(0, 200, bc);
        chk("t1_busy_cycles", 0, bc, 64);
        chk("t1_pass", 0, a_pass, 1);
        chk("t1_err", 0, a_err, 0);
        chk("t1_fv", 0, a_fv, 0);
        chk("t1_last_x", 0, a_x, 3);
        chk("t1_last_y", 0, a_y, 3);
        step();

        // and_in[0] stuck at 0: fails where x[0]&y[0], first at 01/01
        smask[0] = 32'd1;
        pulse_start(0);
        wait_done(0, 200, bc);
        chk("t2_err", 0, a_err, 4);
        chk("t2_fv", 0, a_fv, 1);
        chk("t2_fx", 0, a_fx, 1);
        chk("t2_fy", 0, a_fy, 1);
        chk("t2_pass", 0, a_pass, 0);
        step();

        // WIDTH=3 HOLD=1 with a fault, start while busy ignored, then clean rerun from DONE
        smask[1] = 32'($urandom_range(1, 7));
        omask[1] = 32'($urandom_range(0, 7));
        pulse_start(1);
        repeat (10) step();
        pulse_start(1);
        wait_done(1, 200, bc);
        chk("t3_busy_cycles", 1, bc, 53);
        chk("t3_pass", 1, b_pass, 0);
        smask[1] = '0;
        omask[1] = '0;
        step();
        pulse_start(1);
        @(negedge clk);
        chk("t3_rerun_err", 1, b_err, 0);
        chk("t3_rerun_fv", 1, b_fv, 0);
        chk("t3_rerun_done", 1, b_done, 0);
        wait_done(1, 200, bc);
        chk("t3_rerun_busy_cycles", 1, bc, 63);
        chk("t3_rerun_pass", 1, b_pass, 1);
        step();

        // Abort at cycle 30 with or_in[0] stuck at 1: vectors 0..6 compared, 00/00 and 00/10 fail
        smask[0] = '0;
        omask[0] = 32'd1;
        pulse_start(0);
        repeat (29) step();
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        chk("t4_busy", 0, a_busy, 0);
        chk("t4_done", 0, a_done, 0);
        chk("t4_x", 0, a_x, 0);
        chk("t4_err", 0, a_err, 2);
        chk("t4_fv", 0, a_fv, 1);
        chk("t4_fx", 0, a_fx, 0);
        chk("t4_fy", 0, a_fy, 0);
        step();

        // Asynchronous reset mid-sweep
        smask[0] = 32'($urandom_range(0, 3));
        omask[0] = 32'($urandom_range(0, 3));
        pulse_start(0);
        pulse_start(1);
        repeat (15) step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) check_zero(k);
        step();
        step();
        rst_n = 1'b1;
        step();
        pulse_start(0);
        @(negedge clk);
        chk("t5_x", 0, a_x, 0);
        chk("t5_y", 0, a_y, 0);
        chk("t5_busy", 0, a_busy, 1);
        step();

        // Continuous sweep: never done; one error per 8 cycles saturates the 3-bit counter
        smask[2] = 32'd1;
        omask[2] = '0;
        pulse_start(2);
        dseen = 0;
        repeat (100) begin
            @(negedge clk);
            if (c_done) dseen++;
        end
        chk("t6_done_seen", 2, dseen, 0);
        chk("t6_err_sat", 2, c_err, 7);
        step();
        abort[2] = 1'b1;
        step();
        abort[2] = 1'b0;
        chk("t6_busy", 2, c_busy, 0);
        chk("t6_done", 2, c_done, 0);
        chk("t6_err_held", 2, c_err, 7);

        // Randomized start/abort/fault/reset traffic on all three instances
        repeat (1500) begin
            for (int k = 0; k < NI; k++) begin
                start[k] = ($urandom_range(0, 15) == 0);
                abort[k] = ($urandom_range(0, 60) == 0);
                if ($urandom_range(0, 40) == 0) begin
                    smask[k] = ($urandom_range(0, 1) == 0) ? 32'($urandom) : '0;
                    omask[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : '0;
                end
            end
            rst_n = ($urandom_range(0, 400) != 0);
            step();
        end
        start = '0;
        abort = '0;
        rst_n = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
